// File: rtl/canvas_scheduler_if.sv
// Request/response bundle for canvas_scheduler: draw, clear and scan handshakes
// plus the live bitmap. iDrawVal exists only when CANVAS_ERASE_EN is defined.
interface canvas_scheduler_if;
    logic          iDrawReq;
    logic [4:0]    iDrawX;
    logic [4:0]    iDrawY;
`ifdef CANVAS_ERASE_EN
    logic          iDrawVal;
`endif
    logic          oDrawAck;
    logic          iClearReq;
    logic          oClearAck;
    logic          iScanReq;
    logic [31:0]   oLineData;
    logic [4:0]    oLineIdx;
    logic          oLineValid;
    logic          iLineReady;
    logic          oScanDone;
    logic          oBusy;
    logic [1023:0] oImage;

    modport slave (
        input  iDrawReq, iDrawX, iDrawY,
`ifdef CANVAS_ERASE_EN
        input  iDrawVal,
`endif
        input  iClearReq, iScanReq, iLineReady,
        output oDrawAck, oClearAck, oLineData, oLineIdx, oLineValid, oScanDone, oBusy,
        output oImage
    );

    modport master (
        output iDrawReq, iDrawX, iDrawY,
`ifdef CANVAS_ERASE_EN
        output iDrawVal,
`endif
        output iClearReq, iScanReq, iLineReady,
        input  oDrawAck, oClearAck, oLineData, oLineIdx, oLineValid, oScanDone, oBusy,
        input  oImage
    );
endinterface

// File: rtl/canvas_scheduler.sv
// Owner of the 32x32 one-bit canvas: serialises brush stamps, clears and line readout.
// Define CANVAS_ERASE_EN to add iDrawVal so stamps can erase as well as paint.
module canvas_scheduler (
    input logic              iClk,
    input logic              iRst,
    canvas_scheduler_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] STAMP = 3'd1;
    localparam logic [2:0] DACK  = 3'd2;
    localparam logic [2:0] CLEAR = 3'd3;
    localparam logic [2:0] CACK  = 3'd4;
    localparam logic [2:0] SCAN  = 3'd5;
    localparam logic [2:0] SDONE = 3'd6;

    logic [2:0]    state_q, state_d;
    logic          busy_q, busy_d;
    logic [1023:0] image_q, image_d;
    logic [2:0]    step_q, step_d;
    logic [4:0]    cx_q, cx_d;
    logic [4:0]    cy_q, cy_d;
    // Shared between clear (line being zeroed) and scan (line k on offer).
    logic [4:0]    line_q, line_d;
    logic          wr_val;

`ifdef CANVAS_ERASE_EN
    logic val_q, val_d;
    assign wr_val = val_q;
`else
    assign wr_val = 1'b1;
`endif

    // Stamp cell for the current step; bit 5 set means off-grid, so the write is skipped.
    logic [5:0] sx, sy;
    logic       cell_ok;
    logic [9:0] cell_idx;

    always_comb begin
        sx = {1'b0, cx_q};
        sy = {1'b0, cy_q};
        case (step_q)
            3'd1:    sx = {1'b0, cx_q} + 6'd1;
            3'd2:    sx = {1'b0, cx_q} - 6'd1;
            3'd3:    sy = {1'b0, cy_q} + 6'd1;
            3'd4:    sy = {1'b0, cy_q} - 6'd1;
            default: ;
        endcase
        cell_ok  = !sx[5] && !sy[5];
        cell_idx = {sx[4:0], sy[4:0]};
    end

    always_comb begin
        state_d = state_q;
        image_d = image_q;
        step_d  = step_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        line_d  = line_q;
`ifdef CANVAS_ERASE_EN
        val_d   = val_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.iClearReq) begin
                    state_d = CLEAR;
                    line_d  = 5'd0;
                end else if (bus.iScanReq) begin
                    state_d = SCAN;
                    line_d  = 5'd0;
                end else if (bus.iDrawReq) begin
                    state_d = STAMP;
                    step_d  = 3'd0;
                    cx_d    = bus.iDrawX;
                    cy_d    = bus.iDrawY;
`ifdef CANVAS_ERASE_EN
                    val_d   = bus.iDrawVal;
`endif
                end
            end
            STAMP: begin
                if (cell_ok) begin
                    image_d[cell_idx] = wr_val;
                end
                step_d = step_q + 3'd1;
                if (step_q == 3'd4) begin
                    state_d = DACK;
                end
            end
            DACK: state_d = IDLE;
            CLEAR: begin
                image_d[{line_q, 5'd0} +: 32] = 32'd0;
                line_d = line_q + 5'd1;
                if (line_q == 5'd31) begin
                    state_d = CACK;
                end
            end
            CACK: state_d = IDLE;
            SCAN: begin
                if (bus.iLineReady) begin
                    line_d = line_q + 5'd1;
                    if (line_q == 5'd31) begin
                        state_d = SDONE;
                    end
                end
            end
            SDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            image_q <= '0;
            step_q  <= 3'd0;
            cx_q    <= 5'd0;
            cy_q    <= 5'd0;
            line_q  <= 5'd0;
`ifdef CANVAS_ERASE_EN
            val_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            image_q <= image_d;
            step_q  <= step_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            line_q  <= line_d;
`ifdef CANVAS_ERASE_EN
            val_q   <= val_d;
`endif
        end
    end

    // The canvas cannot change during SCAN, so the offered line is stable while stalled.
    assign bus.oLineValid = (state_q == SCAN);
    assign bus.oLineData  = bus.oLineValid ? image_q[{line_q, 5'd0} +: 32] : 32'd0;
    assign bus.oLineIdx   = bus.oLineValid ? line_q : 5'd0;
    assign bus.oDrawAck   = (state_q == DACK);
    assign bus.oClearAck  = (state_q == CACK);
    assign bus.oScanDone  = (state_q == SDONE);
    assign bus.oBusy      = busy_q;
    assign bus.oImage     = image_q;

endmodule

// File: doc/canvas_scheduler.md
# canvas_scheduler

Owns the 32x32 one-bit drawing canvas and serialises every access to it: brush stamps from the mouse path, whole-canvas clears, and line-by-line readout to the digit classifier. It sits between the mouse/VGA front end and the DNN input. The VGA renderer reads the live bitmap, and the classifier receives a frozen, consistent image over a valid/ready stream.

## Interface
Parameters:
- none; grid is fixed at 32x32, coordinates are 5 bit.

Ports:
- iClk  in  1  single system clock; all logic on posedge
- iRst  in  1  asynchronous, active-high reset
- iDrawReq  in  1  brush stamp request, level, held until oDrawAck
- iDrawX  in  5  stamp centre x
- iDrawY  in  5  stamp centre y
- iDrawVal  in  1  paint (1) / erase (0); present only with CANVAS_ERASE_EN
- oDrawAck  out  1  one-cycle pulse, stamp complete
- iClearReq  in  1  clear request, level, held until oClearAck
- oClearAck  out  1  one-cycle pulse, canvas cleared
- iScanReq  in  1  readout request, level, held until oScanDone
- oLineData  out  32  canvas line oImage[k*32 +: 32] for current line k
- oLineIdx  out  5  current line index k
- oLineValid  out  1  oLineData/oLineIdx valid
- iLineReady  in  1  classifier accepts line
- oScanDone  out  1  one-cycle pulse after line 31 transferred
- oBusy  out  1  high in every state except IDLE
- oImage  out  1024  live bitmap; bit index = x*32 + y

## Operation
- FSM states: IDLE, STAMP, DACK, CLEAR, CACK, SCAN, SDONE.
- IDLE arbitration, fixed priority: iClearReq > iScanReq > iDrawReq. Only one request is accepted per IDLE cycle.
- Draw: the accept edge latches x, y (and iDrawVal) and enters STAMP. Five STAMP cycles write one cell each, in order: (x,y), (x+1,y), (x-1,y), (x,y+1), (x,y-1).
  - A neighbour outside 0..31 is skipped. The cycle is still spent and no write occurs; there is no wrap-around.
  - The written value is 1, or the latched iDrawVal with CANVAS_ERASE_EN.
  - Then DACK asserts oDrawAck for one cycle and returns to IDLE.
- Clear: 32 CLEAR cycles zero lines 0..31, one line per cycle. CACK asserts oClearAck for one cycle, then IDLE.
- Scan: line counter k=0. In SCAN, oLineValid=1 and oLineData/oLineIdx show line k.
  - Transfer happens on an edge with oLineValid && iLineReady; k then increments.
  - oLineData/oLineIdx must stay stable while valid && !ready.
  - After the k=31 transfer, SDONE asserts oScanDone for one cycle, then IDLE.
- The canvas is frozen during SCAN. Pending draw and clear requests wait, no write occurs, and they are served after SDONE by priority.
- Requesters drop their req in the cycle after ack/done. A req still high in IDLE is treated as a new request.
- Requests arriving in non-IDLE states are ignored until IDLE. No request is ever lost while it is held.

## Timing
- Reset (async assert, any state): FSM to IDLE, oImage all 0, k=0, all acks/valid/busy 0, oLineData 0, oLineIdx 0. A transfer or stamp in progress is abandoned, with no ack.
- Draw: request accepted at edge T; cell writes at T+1..T+5; oDrawAck high in cycle T+6. Total 7 cycles from accept to IDLE.
- Clear: accept at T; lines cleared at T+1..T+32; oClearAck high in cycle T+33.
- Scan: first oLineValid in the cycle after accept. With iLineReady tied high, there are 32 transfer cycles, and oScanDone is high in cycle T+33.
- oImage reflects each write on the edge it occurs; oImage is registered, with no combinational path from inputs.
- oBusy is registered with the state.

## Configuration
- CANVAS_ERASE_EN defined:
  - iDrawVal port exists and is latched at accept.
  - Stamps write iDrawVal, so 0 erases.
- CANVAS_ERASE_EN undefined:
  - iDrawVal port is absent.
  - Stamps always write 1; the canvas can only be zeroed by clear or reset.

## Test plan
- Stamp at (5,7) after reset -> bits 5*32+7, 6*32+7, 4*32+7, 5*32+8, 5*32+6 set, and all other bits 0. oDrawAck pulses exactly 6 cycles after accept.
- Stamp at corner (0,31) -> only (0,31), (1,31), (0,30) set, and no wrap bits such as (31,31) or (0,0). Ack timing is unchanged.
- iClearReq, iScanReq, and iDrawReq raised in the same cycle -> clear runs first (ack at T+33), then scan, then the stamp.
- Scan with iLineReady toggling 1,0,0,1,... -> exactly 32 transfers with oLineIdx 0..31 in order and data matching oImage. Data is stable while stalled, and a draw raised mid-scan leaves the canvas unchanged until after oScanDone.
- iRst asserted at stamp cycle 3 -> oImage 0 immediately, no oDrawAck, and FSM in IDLE. A new draw after release completes normally.
- With CANVAS_ERASE_EN, paint at (10,10), then erase at (10,10) with iDrawVal=0 -> all five cells 0 again.
